// File: rtl/pqcuark_keccak_ld_packer.sv
// Repacks 0..8-byte message chunks into dense little-endian 64-bit lanes for the Keccak LD path.
// Lanes appear the cycle after occupancy reaches 8 bytes; in_ready_o depends only on registered occupancy.
module pqcuark_keccak_ld_packer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             start_i,
  input  logic [63:0]      in_data_i,
  input  logic [3:0]       in_nbytes_i,
  input  logic             in_last_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [63:0]      lane_data_o,
  output logic [3:0]       lane_nbytes_o,
  output logic             lane_last_o,
  output logic             lane_valid_o,
  input  logic             lane_ready_i,
  output logic [CNT_W-1:0] byte_cnt_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [191:0]     r_acc;
  logic [191:0]     w_acc_nxt;
  logic [191:0]     w_acc_sh;
  logic [191:0]     w_chunk;
  logic [4:0]       r_acc_cnt;
  logic [4:0]       w_acc_cnt_nxt;
  logic [4:0]       w_off;
  logic [CNT_W-1:0] r_byte_cnt;
  logic [CNT_W-1:0] w_byte_cnt_nxt;
  logic [CNT_W:0]   w_cnt_sum;
  logic [3:0]       w_in_nb;
  logic [3:0]       w_lane_nb;
  logic [63:0]      w_in_mask;
  logic [63:0]      w_lane_mask;
  logic             w_accept;
  logic             w_emit;

  always_comb begin
    w_in_nb     = (in_nbytes_i > 4'd8) ? 4'd8 : in_nbytes_i;
    w_lane_nb   = (r_acc_cnt > 5'd8) ? 4'd8 : r_acc_cnt[3:0];
    w_in_mask   = '0;
    w_lane_mask = '0;
    for (int i = 0; i < 8; i++) begin
      w_in_mask[i*8 +: 8]   = (4'(i) < w_in_nb)   ? 8'hFF : 8'h00;
      w_lane_mask[i*8 +: 8] = (4'(i) < w_lane_nb) ? 8'hFF : 8'h00;
    end
  end

  // Every output is a function of registers only, so no lane_ready_i -> in_ready_o path exists.
  always_comb begin
    in_ready_o    = (r_state == S_RUN) && (r_acc_cnt <= 5'd15);
    lane_valid_o  = (r_acc_cnt >= 5'd8) || (r_state == S_DRAIN);
    lane_last_o   = (r_state == S_DRAIN) && (r_acc_cnt <= 5'd8);
    lane_nbytes_o = w_lane_nb;
    lane_data_o   = r_acc[63:0] & w_lane_mask;
    byte_cnt_o    = r_byte_cnt;
    busy_o        = (r_state != S_IDLE);
  end

  assign w_accept = in_valid_i & in_ready_o;
  assign w_emit   = lane_valid_o & lane_ready_i;

  // Bytes above acc_cnt are kept zero, so insertion is a plain OR at the post-shift offset.
  always_comb begin
    w_acc_sh      = w_emit ? (r_acc >> 64) : r_acc;
    w_off         = r_acc_cnt - (w_emit ? {1'b0, w_lane_nb} : 5'd0);
    w_chunk       = {128'd0, in_data_i & w_in_mask};
    w_acc_nxt     = w_accept ? (w_acc_sh | (w_chunk << {w_off, 3'b000})) : w_acc_sh;
    w_acc_cnt_nxt = w_off + (w_accept ? {1'b0, w_in_nb} : 5'd0);
    w_cnt_sum     = {1'b0, r_byte_cnt} + {{(CNT_W-3){1'b0}}, w_in_nb};
    w_byte_cnt_nxt = r_byte_cnt;
    if (w_accept) begin
      w_byte_cnt_nxt = w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && in_last_i) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_emit && lane_last_o) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (start_i) w_state_nxt = S_RUN;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i || start_i) begin
      r_acc      <= '0;
      r_acc_cnt  <= '0;
      r_byte_cnt <= '0;
    end else begin
      r_acc      <= w_acc_nxt;
      r_acc_cnt  <= w_acc_cnt_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pqcuark_keccak_ld_packer.sv
// Bench for pqcuark_keccak_ld_packer: byte-queue reference model, per-cycle compare, directed and random messages.
module tb_pqcuark_keccak_ld_packer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        start_i = 1'b0;
  logic [63:0] in_data_i = '0;
  logic [3:0]  in_nbytes_i = '0;
  logic        in_last_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [63:0] lane_data_o;
  logic [3:0]  lane_nbytes_o;
  logic        lane_last_o;
  logic        lane_valid_o;
  logic        lane_ready_i = 1'b1;
  logic [15:0] byte_cnt_o;
  logic        busy_o;

  pqcuark_keccak_ld_packer #(.CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .start_i(start_i),
    .in_data_i(in_data_i), .in_nbytes_i(in_nbytes_i), .in_last_i(in_last_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .lane_data_o(lane_data_o), .lane_nbytes_o(lane_nbytes_o), .lane_last_o(lane_last_o),
    .lane_valid_o(lane_valid_o), .lane_ready_i(lane_ready_i),
    .byte_cnt_o(byte_cnt_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] d;
    int          nb;
    bit          last;
    int          cyc;
  } lane_t;

  int         checks = 0;
  int         errors = 0;
  bit         chk_en = 0;
  int         rdy_mode = 0;
  int         cyc = 0;
  logic [7:0] q[$];
  logic [7:0] sent[$];
  lane_t      lanes[$];
  bit         m_run = 0;
  bit         m_drain = 0;
  int         m_bc = 0;

  function automatic int exp_nb();
    return (q.size() > 8) ? 8 : q.size();
  endfunction
  function automatic bit exp_lv();
    return (q.size() >= 8) || m_drain;
  endfunction
  function automatic bit exp_last();
    return m_drain && (q.size() <= 8);
  endfunction
  function automatic bit exp_ir();
    return m_run && !m_drain && (q.size() <= 15);
  endfunction
  function automatic logic [63:0] exp_data();
    logic [63:0] d = '0;
    for (int i = 0; i < exp_nb(); i++) d[i*8 +: 8] = q[i];
    return d;
  endfunction

  // Reference model: message is a byte queue; lanes are the first min(size,8) bytes.
  bit    mv_e, mv_a, mv_last;
  int    mv_nb;
  lane_t mv_lane;
  always @(posedge clk_i) begin
    cyc++;
    if (rst_i || flush_i) begin
      q.delete(); m_run = 0; m_drain = 0; m_bc = 0;
    end else if (start_i) begin
      q.delete(); m_run = 1; m_drain = 0; m_bc = 0;
    end else begin
      mv_e    = exp_lv() && lane_ready_i;
      mv_a    = exp_ir() && in_valid_i;
      mv_last = exp_last();
      if (mv_e) begin
        mv_lane.d = exp_data(); mv_lane.nb = exp_nb(); mv_lane.last = mv_last; mv_lane.cyc = cyc;
        lanes.push_back(mv_lane);
        repeat (mv_lane.nb) void'(q.pop_front());
        if (mv_last) begin m_run = 0; m_drain = 0; end
      end
      if (mv_a) begin
        mv_nb = (in_nbytes_i > 4'd8) ? 8 : int'(in_nbytes_i);
        for (int i = 0; i < mv_nb; i++) q.push_back(in_data_i[i*8 +: 8]);
        m_bc = (m_bc + mv_nb > 65535) ? 65535 : m_bc + mv_nb;
        if (in_last_i) m_drain = 1;
      end
    end
  end

  bit cmp_bad;
  always @(negedge clk_i) begin
    if (chk_en) begin
      cmp_bad = (in_ready_o !== exp_ir()) || (lane_valid_o !== exp_lv()) ||
                (busy_o !== m_run) || (byte_cnt_o !== 16'(m_bc));
      if (exp_lv())
        cmp_bad = cmp_bad || (lane_data_o !== exp_data()) ||
                  (lane_nbytes_o !== 4'(exp_nb())) || (lane_last_o !== exp_last());
      checks++;
      if (cmp_bad) begin
        errors++;
        $display("FAIL cycle_compare cyc=%0d got rdy=%b vld=%b data=%h nb=%0d last=%b busy=%b cnt=%0d want rdy=%b vld=%b data=%h nb=%0d last=%b busy=%b cnt=%0d",
                 cyc, in_ready_o, lane_valid_o, lane_data_o, lane_nbytes_o, lane_last_o, busy_o, byte_cnt_o,
                 exp_ir(), exp_lv(), exp_data(), exp_nb(), exp_last(), m_run, m_bc);
      end
    end
  end

  initial begin
    lane_ready_i = 1'b1;
    forever begin
      @(posedge clk_i); #1;
      case (rdy_mode)
        0:       lane_ready_i = 1'b1;
        1:       lane_ready_i = 1'b0;
        default: lane_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic do_start();
    lanes.delete(); sent.delete();
    start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  task automatic send(input logic [63:0] d, input logic [3:0] nb, input bit last);
    bit ok = 0;
    bit r;
    int nbc;
    in_data_i = d; in_nbytes_i = nb; in_last_i = last; in_valid_i = 1'b1;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk_i); r = in_ready_o;
      tick();
      if (r) ok = 1;
    end
    in_valid_i = 1'b0; in_last_i = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout got no accept want accept");
    end else begin
      nbc = (nb > 4'd8) ? 8 : int'(nb);
      for (int i = 0; i < nbc; i++) sent.push_back(d[i*8 +: 8]);
    end
  endtask

  task automatic wait_idle(input string nm);
    bit done = 0;
    for (int k = 0; k < 4000 && !done; k++) begin
      @(negedge clk_i);
      if (!busy_o) done = 1;
    end
    chk(nm, 128'(done), 128'(1));
  endtask

  task automatic chk_lane(input string nm, input int idx, input logic [63:0] d, input int nb, input bit last);
    if (lanes.size() <= idx) chk({nm, "_present"}, 128'(lanes.size()), 128'(idx + 1));
    else chk(nm, {lanes[idx].d, 32'(lanes[idx].nb), 31'd0, lanes[idx].last}, {d, 32'(nb), 31'd0, last});
  endtask

  logic [7:0] rx[$];
  bit         rok;
  int         nch;

  initial begin
    repeat (3) tick();
    rst_i = 1'b0;
    chk("reset_outputs", {in_ready_o, lane_valid_o, lane_last_o, lane_nbytes_o, lane_data_o, byte_cnt_o, busy_o}, '0);
    chk_en = 1;

    // three full chunks, lanes on consecutive cycles
    rdy_mode = 0;
    do_start();
    send(64'h0706050403020100, 4'd8, 0);
    send(64'h0F0E0D0C0B0A0908, 4'd8, 0);
    send(64'h1716151413121110, 4'd8, 1);
    wait_idle("t1_idle");
    chk_lane("t1_lane0", 0, 64'h0706050403020100, 8, 0);
    chk_lane("t1_lane1", 1, 64'h0F0E0D0C0B0A0908, 8, 0);
    chk_lane("t1_lane2", 2, 64'h1716151413121110, 8, 1);
    if (lanes.size() == 3) chk("t1_back_to_back", 128'(lanes[2].cyc - lanes[0].cyc), 128'(2));
    chk("t1_byte_cnt", 128'(byte_cnt_o), 128'(24));

    // three-byte chunks with garbage above nbytes
    do_start();
    send(64'h5555555555CCBBAA, 4'd3, 0);
    send(64'hA5A5A5A5A5FFEEDD, 4'd3, 0);
    send(64'h0123456789332211, 4'd3, 1);
    wait_idle("t2_idle");
    chk("t2_nlanes", 128'(lanes.size()), 128'(2));
    chk_lane("t2_lane0", 0, 64'h2211FFEEDDCCBBAA, 8, 0);
    chk_lane("t2_lane1", 1, 64'h0000000000000033, 1, 1);
    chk("t2_byte_cnt", 128'(byte_cnt_o), 128'(9));

    // backpressure: occupancy reaches 16, in_ready drops, lane held
    rdy_mode = 1;
    do_start();
    send(64'h1111111111111111, 4'd8, 0);
    send(64'h2222222222222222, 4'd8, 0);
    in_data_i = 64'h3333333333333333; in_nbytes_i = 4'd8; in_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk("t3_in_ready_low", 128'(in_ready_o), 128'(0));
      chk("t3_lane_held", 128'(lane_data_o), 128'h1111111111111111);
    end
    in_valid_i = 1'b0;
    rdy_mode = 0;
    send(64'h3333333333333333, 4'd8, 0);
    send(64'h4444444444444444, 4'd8, 1);
    wait_idle("t3_idle");
    chk("t3_nlanes", 128'(lanes.size()), 128'(4));
    chk_lane("t3_lane0", 0, 64'h1111111111111111, 8, 0);
    chk_lane("t3_lane2", 2, 64'h3333333333333333, 8, 0);
    chk_lane("t3_lane3", 3, 64'h4444444444444444, 8, 1);

    // empty message
    do_start();
    send(64'hDEADBEEFDEADBEEF, 4'd0, 1);
    wait_idle("t4_idle");
    chk("t4_nlanes", 128'(lanes.size()), 128'(1));
    chk_lane("t4_lane0", 0, 64'h0, 0, 1);

    // garbage above nbytes, plus nbytes>8 clamps to 8
    do_start();
    send(64'hFFFFFFFFFFFF1234, 4'd2, 1);
    wait_idle("t5_idle");
    chk_lane("t5_lane0", 0, 64'h0000000000001234, 2, 1);
    do_start();
    send(64'h8877665544332211, 4'd15, 1);
    wait_idle("t5b_idle");
    chk_lane("t5b_lane0", 0, 64'h8877665544332211, 8, 1);

    // reset and flush with 12 bytes buffered
    for (int f = 0; f < 2; f++) begin
      rdy_mode = 1;
      do_start();
      send(64'h0807060504030201, 4'd8, 0);
      send(64'h0C0B0A09, 4'd4, 0);
      if (f == 0) rst_i = 1'b1; else flush_i = 1'b1;
      tick();
      rst_i = 1'b0; flush_i = 1'b0;
      chk(f == 0 ? "t6_rst_outputs" : "t6_flush_outputs",
          {in_ready_o, lane_valid_o, lane_last_o, lane_nbytes_o, lane_data_o, byte_cnt_o, busy_o}, '0);
    end

    // restart in DRAIN discards old bytes
    do_start();
    send(64'h0807060504030201, 4'd8, 0);
    send(64'h0C0B0A09, 4'd4, 1);
    chk("t7_draining_busy", 128'(busy_o), 128'(1));
    do_start();
    chk("t7_restart_cnt", 128'(byte_cnt_o), 128'(0));
    chk("t7_restart_lv", 128'(lane_valid_o), 128'(0));
    rdy_mode = 0;
    send(64'h0000000000CCBBAA, 4'd3, 1);
    wait_idle("t7_idle");
    chk("t7_nlanes", 128'(lanes.size()), 128'(1));
    chk_lane("t7_lane0", 0, 64'h0000000000CCBBAA, 3, 1);

    // random messages: emitted byte stream must equal accepted bytes
    for (int m = 0; m < 60; m++) begin
      rdy_mode = ($urandom_range(0, 3) == 0) ? 0 : 2;
      do_start();
      nch = $urandom_range(1, 7);
      for (int c = 0; c < nch; c++) begin
        send({$urandom, $urandom}, 4'($urandom_range(0, 15)), c == nch - 1);
        repeat ($urandom_range(0, 2)) tick();
      end
      wait_idle("rand_idle");
      rx.delete(); rok = (lanes.size() > 0) && lanes[lanes.size()-1].last;
      for (int l = 0; l < lanes.size(); l++) begin
        for (int i = 0; i < lanes[l].nb; i++) rx.push_back(lanes[l].d[i*8 +: 8]);
        if (l < lanes.size() - 1 && (lanes[l].nb != 8 || lanes[l].last)) rok = 0;
      end
      if (rx.size() != sent.size()) rok = 0;
      else for (int i = 0; i < rx.size(); i++) if (rx[i] !== sent[i]) rok = 0;
      chk("rand_stream", 128'(rok), 128'(1));
    end

    // byte counter saturation
    rdy_mode = 0;
    do_start();
    for (int c = 0; c < 8200; c++) send({$urandom, $urandom}, 4'd8, c == 8199);
    wait_idle("sat_idle");
    chk("sat_byte_cnt", 128'(byte_cnt_o), 128'(65535));

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
